// File: rtl/pacman_input_pkg.sv
// Shared constants for the Pac-Man button input path: debounce state encoding,
// direction channel indices and the default qualification time.
package pacman_input_pkg;

    typedef logic [1:0] dbnc_state_t;

    localparam dbnc_state_t S_LOW       = 2'd0;
    localparam dbnc_state_t S_WAIT_HIGH = 2'd1;
    localparam dbnc_state_t S_HIGH      = 2'd2;
    localparam dbnc_state_t S_WAIT_LOW  = 2'd3;

    localparam int unsigned DIR_UP    = 0;
    localparam int unsigned DIR_DOWN  = 1;
    localparam int unsigned DIR_LEFT  = 2;
    localparam int unsigned DIR_RIGHT = 3;

    // 10 ms at 100 MHz
    localparam int unsigned STABLE_CYCLES_DEF = 1000000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, 4-state qualification FSM and
// saturating stability counter. Exposes its FSM state to the parent.
module btn_debounce_ch
    import pacman_input_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned CNT_W         = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_raw_i,
    output dbnc_state_t state_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             sync_s;
    dbnc_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= S_LOW;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sync_s  = sync_q[1];
    assign cnt_inc = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);

    // The entry cycle counts as the first stable sample, so qualification
    // completes when the incremented count reaches STABLE_CYCLES-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_LOW: begin
                if (sync_s) begin
                    state_d = S_WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            S_WAIT_HIGH: begin
                if (!sync_s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            S_HIGH: begin
                if (!sync_s) begin
                    state_d = S_WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOW: begin
                if (sync_s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer with registered outputs.
// Define BTN_LOCKOUT_EN to allow at most one active direction at a time.
module btn_debounce
    import pacman_input_pkg::*;
#(
    parameter int unsigned N_BTN         = 4,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned CNT_W         = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_db,
    output logic             any_active
);

    dbnc_state_t      ch_state [N_BTN];
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] db_d, db_q;
    logic             act_q;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .btn_raw_i (btn_raw[g]),
            .state_o   (ch_state[g])
        );
        assign level[g] = (ch_state[g] == S_HIGH) || (ch_state[g] == S_WAIT_LOW);
    end

`ifdef BTN_LOCKOUT_EN
    logic [N_BTN-1:0] high;

    for (genvar g = 0; g < N_BTN; g++) begin : g_high
        assign high[g] = (ch_state[g] == S_HIGH);
    end

    // Owner keeps the output while its level is 1; once freed, the output goes
    // idle for one cycle, then the lowest-index channel in S_HIGH takes over.
    always_comb begin
        db_d = '0;
        if (db_q == '0) begin
            db_d = high & (~high + N_BTN'(1));
        end else if ((db_q & level) != '0) begin
            db_d = db_q;
        end
    end
`else
    always_comb begin
        db_d = level;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q  <= '0;
            act_q <= 1'b0;
        end else begin
            db_q  <= db_d;
            act_q <= |db_d;
        end
    end

    assign btn_db     = db_q;
    assign any_active = act_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with STABLE_CYCLES=4 (7-cycle latency).
// Covers both builds: lockout scenario with BTN_LOCKOUT_EN, all-pressed otherwise.
module tb_btn_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_db;
    logic       any_active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_debounce #(
        .N_BTN         (4),
        .STABLE_CYCLES (4),
        .CNT_W         (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_db     (btn_db),
        .any_active (any_active)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = 4'b0000;
        tick(2);
        chk("reset_db", btn_db, 4'b0000);
        chk("reset_any", any_active, 1'b0);
        rst = 1'b0;
        tick(2);

        // clean rise and fall on channel 0
        btn_raw = 4'b0001;
        tick(6);
        chk("rise_early_db", btn_db, 4'b0000);
        chk("rise_early_any", any_active, 1'b0);
        tick(1);
        chk("rise_db", btn_db, 4'b0001);
        chk("rise_any", any_active, 1'b1);
        btn_raw = 4'b0000;
        tick(6);
        chk("fall_early_db", btn_db, 4'b0001);
        tick(1);
        chk("fall_db", btn_db, 4'b0000);
        chk("fall_any", any_active, 1'b0);
        tick(2);

        // bounce on channel 1, then settle high
        for (int i = 0; i < 4; i++) begin
            btn_raw = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            tick(1);
            chk("bounce_hold_db", btn_db, 4'b0000);
        end
        btn_raw = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("bounce_settle_db", btn_db, 4'b0000);
        end
        tick(1);
        chk("bounce_rise_db", btn_db, 4'b0010);
        btn_raw = 4'b0000;
        tick(7);
        chk("bounce_fall_db", btn_db, 4'b0000);
        tick(2);

        // glitch one cycle shorter than the qualification time
        btn_raw = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("glitch_high_db", btn_db, 4'b0000);
        end
        btn_raw = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("glitch_after_db", btn_db, 4'b0000);
            chk("glitch_after_any", any_active, 1'b0);
        end

        // reset mid-qualification on channel 3, button held through release
        btn_raw = 4'b1000;
        tick(3);
        rst = 1'b1;
        #1;
        chk("midrst_db", btn_db, 4'b0000);
        tick(2);
        rst = 1'b0;
        tick(6);
        chk("midrst_early_db", btn_db, 4'b0000);
        tick(1);
        chk("midrst_rise_db", btn_db, 4'b1000);
        chk("midrst_rise_any", any_active, 1'b1);
        btn_raw = 4'b0000;
        tick(8);
        chk("midrst_fall_db", btn_db, 4'b0000);

`ifdef BTN_LOCKOUT_EN
        btn_raw = 4'b0110;
        tick(6);
        chk("lock_early_db", btn_db, 4'b0000);
        tick(1);
        chk("lock_own_db", btn_db, 4'b0010);
        chk("lock_own_any", any_active, 1'b1);
        tick(3);
        chk("lock_hold_db", btn_db, 4'b0010);
        btn_raw = 4'b0100;
        tick(6);
        chk("lock_rel_early_db", btn_db, 4'b0010);
        tick(1);
        chk("lock_free_db", btn_db, 4'b0000);
        chk("lock_free_any", any_active, 1'b0);
        tick(1);
        chk("lock_handover_db", btn_db, 4'b0100);
        chk("lock_handover_any", any_active, 1'b1);
`else
        btn_raw = 4'b1111;
        tick(6);
        chk("all_early_db", btn_db, 4'b0000);
        tick(1);
        chk("all_db", btn_db, 4'b1111);
        chk("all_any", any_active, 1'b1);
`endif

        // asynchronous reset clears outputs without a clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_db", btn_db, 4'b0000);
        chk("async_rst_any", any_active, 1'b0);
        btn_raw = 4'b0000;
        tick(1);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL provide parameter N_BTN, default 4, number of button channels (index 0=up, 1=down, 2=left, 3=right).
REQ-002 SHALL provide parameter STABLE_CYCLES, default 1000000, the consecutive stable cycles needed to accept a change (10 ms at 100 MHz); legal range 2 to 2^CNT_W-1.
REQ-003 SHALL provide parameter CNT_W, default 20, the counter width.
REQ-004 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port btn_raw, input, N_BTN, asynchronous bouncing button levels, active-high.
REQ-007 SHALL have port btn_db, output, N_BTN, debounced registered levels that feed the downstream edge detectors.
REQ-008 SHALL have port any_active, output, 1, registered OR of btn_db.

Function
REQ-009 SHALL synchronise each btn_raw bit through a 2-flop synchroniser before any other use.
REQ-010 SHALL implement per-channel FSM states S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW.
REQ-011 S_LOW: sync=1 -> S_WAIT_HIGH with counter cleared to 0; otherwise stay.
REQ-012 S_WAIT_HIGH: sync=1 increments counter; when counter reaches STABLE_CYCLES-1 while sync=1 -> S_HIGH; sync=0 on any cycle -> S_LOW, counter cleared (bounce rejected).
REQ-013 S_HIGH and S_WAIT_LOW SHALL mirror REQ-011 and REQ-012 with polarity inverted.
REQ-014 Channel level SHALL be 1 in S_HIGH and S_WAIT_LOW, and 0 in S_LOW and S_WAIT_HIGH.
REQ-015 Latency from a clean btn_raw step to the btn_db change SHALL be exactly 2 + STABLE_CYCLES + 1 clk cycles.
REQ-016 Counter SHALL never wrap; it is cleared on every state entry and saturates at STABLE_CYCLES-1.
REQ-017 Channels SHALL be fully independent unless BTN_LOCKOUT_EN is defined.
REQ-018 A glitch shorter than STABLE_CYCLES cycles SHALL produce no btn_db change.
REQ-019 any_active SHALL update on the same cycle as btn_db.

Reset
REQ-020 rst SHALL asynchronously clear synchroniser flops, counters, btn_db and any_active to 0, and set all FSMs to S_LOW.
REQ-021 A button held through reset release SHALL be re-qualified from S_LOW, taking full latency.
REQ-022 rst asserted mid-qualification SHALL abandon the partial count.

Configuration
REQ-023 Macro BTN_LOCKOUT_EN defined: at most one btn_db bit SHALL be 1. The first channel to reach S_HIGH owns the output; other channels' btn_db bits stay 0 until the owner's level returns to 0. On simultaneous qualification the lowest index wins. A masked channel still in S_HIGH when ownership frees SHALL become owner on the next cycle, again lowest index first.
REQ-024 Macro BTN_LOCKOUT_EN undefined: btn_db SHALL equal the per-channel levels directly, with no ownership logic synthesised.

Structure
REQ-025 Package pacman_input_pkg SHALL hold the debounce state enum, channel index constants DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT, and the default STABLE_CYCLES constant.
REQ-026 Sub-module btn_debounce_ch SHALL implement one channel (synchroniser, FSM, counter); btn_debounce SHALL instantiate N_BTN copies plus lockout/output registers.

Verification (bench uses STABLE_CYCLES=4)
REQ-027 Clean rise: btn_raw[0] 0->1 and held -> btn_db=4'b0001 exactly 7 cycles later; any_active=1 on the same cycle.
REQ-028 Bounce: btn_raw[1] toggles 1,0,1,0 each cycle then holds 1 -> btn_db[1] stays 0 during toggling and rises 7 cycles after the final rise.
REQ-029 Short glitch: btn_raw[2]=1 for 3 cycles then 0 -> btn_db stays 4'b0000 throughout.
REQ-030 Reset mid-count: btn_raw[3]=1, rst pulsed 3 cycles after the rise and released while still held -> btn_db[3] rises 7 cycles after rst deasserts.
REQ-031 Lockout (BTN_LOCKOUT_EN): btn_raw=4'b0110 applied together -> btn_db=4'b0010; btn_raw[1] released -> btn_db[1] falls after 7 cycles and btn_db becomes 4'b0100 the next cycle.
REQ-032 No lockout (macro undefined): btn_raw=4'b1111 -> btn_db=4'b1111 after 7 cycles.
